// File: rtl/current_sense_scheduler.sv
// current_sense_scheduler: sequences TLI4970 current-sensor reads over a shared
// SPI engine once per update period. Each enabled channel gets one 16-bit
// transfer. Current frames are decoded to signed mA; status frames and
// transfer timeouts raise sticky per-channel error flags.
// Optional feature: define CURRENT_SENSE_OVERCURRENT_EN to enable per-channel
// sticky overcurrent flags against overcurrent_limit.
module current_sense_scheduler #(
    parameter int unsigned NUM_SENSORS    = 4,
    parameter int unsigned CLOCK_FREQ     = 16_000_000,
    parameter int unsigned UPDATE_FREQ    = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_SENSORS-1:0]   chan_mask,
    output logic                     xfer_req,
    output logic [2:0]               xfer_sel,
    input  logic                     xfer_done,
    input  logic [15:0]              xfer_data,
    output logic [16*NUM_SENSORS-1:0] current,
    output logic [NUM_SENSORS-1:0]   chan_valid,
    output logic [NUM_SENSORS-1:0]   chan_error,
    output logic                     sweep_done,
    output logic                     overrun,
    input  logic                     err_clear,
    input  logic [14:0]              overcurrent_limit,
    output logic [NUM_SENSORS-1:0]   overcurrent
);

    localparam int unsigned PERIOD = CLOCK_FREQ / UPDATE_FREQ;
    localparam int unsigned CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IDX_W  = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        WAIT,
        STORE,
        NEXT
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]       period_cnt;
    logic                   tick;
    logic [NUM_SENSORS-1:0] mask_q;
    logic [IDX_W-1:0]       chan_idx;
    logic [TMO_W-1:0]       wait_cnt;
    logic                   timeout;
    logic [15:0]            data_q;
    logic [15:0]            frame_val;
    logic [15:0]            cur_q [NUM_SENSORS];

    logic                   first_found;
    logic [IDX_W-1:0]       first_idx;
    logic                   next_found;
    logic [IDX_W-1:0]       next_idx;
    logic                   start_sweep;

    assign tick        = (period_cnt == CNT_W'(PERIOD - 1));
    assign timeout     = (wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign frame_val   = {3'b000, data_q[12:0]} - 16'd4096;
    assign start_sweep = tick && enable && first_found;

    // Free-running period counter; the wrap cycle is the sweep tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt <= '0;
        end else if (tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // Lowest set bit of the live mask, and next set bit above the current channel in the sampled mask.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
            if (chan_mask[i] && !first_found) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(i);
            end
            if (mask_q[i] && (i > 32'(chan_idx)) && !next_found) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(i);
            end
        end
    end

    // Sweep state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the sweep sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_sweep) state_next = SELECT;
            SELECT:  state_next = WAIT;
            WAIT: begin
                if (xfer_done) begin
                    state_next = STORE;
                end else if (timeout) begin
                    state_next = NEXT;
                end
            end
            STORE:   state_next = NEXT;
            NEXT:    state_next = next_found ? SELECT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transfer handshake, frame decode and per-channel status registers.
    // Clears are written before sets so a coincident error event wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_req   <= 1'b0;
            xfer_sel   <= '0;
            mask_q     <= '0;
            chan_idx   <= '0;
            wait_cnt   <= '0;
            data_q     <= '0;
            chan_valid <= '0;
            chan_error <= '0;
            sweep_done <= 1'b0;
            overrun    <= 1'b0;
            for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
                cur_q[i] <= '0;
            end
        end else begin
            sweep_done <= 1'b0;
            if (err_clear) begin
                chan_error <= '0;
                overrun    <= 1'b0;
            end
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_sweep) begin
                        mask_q   <= chan_mask;
                        chan_idx <= first_idx;
                    end
                end
                SELECT: begin
                    xfer_req <= 1'b1;
                    xfer_sel <= 3'(chan_idx);
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (xfer_done) begin
                        xfer_req <= 1'b0;
                        data_q   <= xfer_data;
                    end else if (timeout) begin
                        xfer_req             <= 1'b0;
                        chan_error[chan_idx] <= 1'b1;
                        chan_valid[chan_idx] <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                STORE: begin
                    if (data_q[15]) begin
                        chan_valid[chan_idx] <= 1'b0;
                        chan_error[chan_idx] <= 1'b1;
                    end else begin
                        cur_q[chan_idx]      <= frame_val;
                        chan_valid[chan_idx] <= 1'b1;
                    end
                end
                NEXT: begin
                    if (next_found) begin
                        chan_idx <= next_idx;
                    end else begin
                        sweep_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_cur
        assign current[16*g +: 16] = cur_q[g];
    end

    // Bits 14:13 of a frame carry no current information.
    logic unused_frame_bits;
    assign unused_frame_bits = ^data_q[14:13];

`ifdef CURRENT_SENSE_OVERCURRENT_EN
    logic [15:0]            frame_mag;
    logic [NUM_SENSORS-1:0] oc_q;

    assign frame_mag = frame_val[15] ? (~frame_val + 16'd1) : frame_val;

    // Sticky overcurrent flag per channel, raised on a current frame whose magnitude exceeds the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            oc_q <= '0;
        end else begin
            if (err_clear) begin
                oc_q <= '0;
            end
            if ((state == STORE) && !data_q[15] && (frame_mag > {1'b0, overcurrent_limit})) begin
                oc_q[chan_idx] <= 1'b1;
            end
        end
    end

    assign overcurrent = oc_q;
`else
    logic unused_limit;
    assign unused_limit = ^overcurrent_limit;
    assign overcurrent  = '0;
`endif

endmodule

// File: doc/current_sense_scheduler.md
CURRENT_SENSE_SCHEDULER -- requirements
Module: current_sense_scheduler

Interface
REQ-001 SHALL provide parameter NUM_SENSORS, default 4: number of TLI4970 channels sequenced (1..8).
REQ-002 SHALL provide parameter CLOCK_FREQ, default 16_000_000: clk frequency in Hz.
REQ-003 SHALL provide parameter UPDATE_FREQ, default 1000: sweep rate in Hz; PERIOD = CLOCK_FREQ/UPDATE_FREQ cycles.
REQ-004 SHALL provide parameter TIMEOUT_CYCLES, default 1024: maximum cycles from xfer_req rise to xfer_done.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1: high permits new sweeps.
REQ-008 SHALL have port chan_mask, input, NUM_SENSORS: bit i high includes channel i in each sweep.
REQ-009 SHALL have port xfer_req, output, 1: request one 16-bit SPI read from the shared engine.
REQ-010 SHALL have port xfer_sel, output, 3: channel (CS index) for the pending transfer.
REQ-011 SHALL have port xfer_done, input, 1: one-cycle pulse, transfer complete.
REQ-012 SHALL have port xfer_data, input, 16: received word, valid only while xfer_done is high.
REQ-013 SHALL have port current, output, 16*NUM_SENSORS: signed mA per channel; channel i occupies bits [16i+15:16i].
REQ-014 SHALL have port chan_valid, output, NUM_SENSORS: bit i high means current[i] holds a fresh current frame.
REQ-015 SHALL have port chan_error, output, NUM_SENSORS: sticky; status frame or timeout seen on channel i.
REQ-016 SHALL have port sweep_done, output, 1: one-cycle pulse when a sweep completes.
REQ-017 SHALL have port overrun, output, 1: sticky; a period tick arrived while a sweep was still active.
REQ-018 SHALL have port err_clear, input, 1: one-cycle pulse clearing chan_error, overrun and overcurrent.
REQ-019 SHALL have ports overcurrent_limit, input, 15 (unsigned mA), and overcurrent, output, NUM_SENSORS (sticky per channel).

Function
REQ-020 SHALL count 0..PERIOD-1 in a free-running period counter; the wrap cycle is the tick.
REQ-021 SHALL use states IDLE, SELECT, WAIT, STORE, NEXT.
REQ-022 On a tick in IDLE with enable=1 and chan_mask nonzero, SHALL go to SELECT at the lowest set mask bit; otherwise it SHALL stay in IDLE.
REQ-023 In SELECT, SHALL assert xfer_req, drive xfer_sel, and go to WAIT; xfer_sel SHALL stay stable while xfer_req is high.
REQ-024 In WAIT, on xfer_done SHALL deassert xfer_req the next cycle, latch xfer_data, and go to STORE.
REQ-025 If WAIT lasts TIMEOUT_CYCLES without xfer_done, SHALL deassert xfer_req, set chan_error[i], clear chan_valid[i], and go to NEXT.
REQ-026 In STORE with xfer_data[15]=0, SHALL set current[i] = {3'b0,data[12:0]} - 4096 as a 16-bit signed value (range -4096..+4095) and set chan_valid[i].
REQ-027 In STORE with xfer_data[15]=1 (status frame), SHALL leave current[i] unchanged, clear chan_valid[i], and set chan_error[i].
REQ-028 NEXT SHALL advance to the next higher set mask bit and go to SELECT; after the last set bit it SHALL pulse sweep_done and go to IDLE.
REQ-029 chan_mask SHALL be sampled once at sweep start; changes mid-sweep SHALL take effect at the next sweep.
REQ-030 A tick while not in IDLE SHALL be dropped and SHALL set overrun.
REQ-031 enable falling mid-sweep SHALL let the sweep complete; no new sweep SHALL start.
REQ-032 If err_clear coincides with a new error event, the set SHALL win.
REQ-033 xfer_done outside WAIT SHALL be ignored.

Reset
REQ-034 While reset is high, SHALL force state IDLE, period counter 0, xfer_req 0, xfer_sel 0, current all 0, chan_valid 0, chan_error 0, overcurrent 0, sweep_done 0, overrun 0.
REQ-035 Reset mid-transfer SHALL drop xfer_req in the next cycle and discard any later xfer_done.

Configuration
REQ-036 Macro CURRENT_SENSE_OVERCURRENT_EN defined: in STORE on a current frame, SHALL set overcurrent[i] if |current[i]| > overcurrent_limit; the flag stays set until err_clear.
REQ-037 Macro CURRENT_SENSE_OVERCURRENT_EN undefined: overcurrent SHALL be constant 0 and overcurrent_limit SHALL be ignored.

Verification
REQ-038 Reset, then PERIOD=100, mask=4'b0101, engine returns 16'h1400 -> xfer_sel 0 then 2, current[0]=current[2]=+1024, chan_valid=4'b0101, one sweep_done.
REQ-039 Channel 1 returns 16'h8123 -> current[1] unchanged, chan_valid[1]=0, chan_error[1]=1; err_clear pulse -> chan_error=0.
REQ-040 Engine never asserts xfer_done on channel 3 -> xfer_req drops after 1024 cycles, chan_error[3]=1, sweep_done still pulses.
REQ-041 Engine delays xfer_done beyond PERIOD -> overrun=1, no second sweep starts until IDLE.
REQ-042 With CURRENT_SENSE_OVERCURRENT_EN, limit=500, data 16'h0C00 (-1024) -> overcurrent[i]=1; without the macro -> overcurrent=0.
REQ-043 Reset asserted while in WAIT -> xfer_req=0 next cycle, all outputs at reset values, a late xfer_done is ignored.
